// File: rtl/fifo_pkg.sv
// Shared FIFO sizing helpers and threshold legality checks.
// Used by both the single- and dual-clock FIFOs.
package fifo_pkg;

  function automatic int ptr_width(input int addrsize);
    return addrsize + 1;
  endfunction

  function automatic int depth_of(input int addrsize);
    return 1 << addrsize;
  endfunction

  function automatic bit thr_ok(
    input int addrsize,
    input int afull,
    input int aempty
  );
    int d;
    d = depth_of(addrsize);
    return (addrsize >= 1) &&
           (afull >= 1) && (afull <= d) &&
           (aempty >= 0) && (aempty <= d - 1) &&
           (aempty < afull);
  endfunction

endpackage

// File: rtl/sfifo_mem.sv
// Simple dual-port RAM: synchronous write, registered read.
// The array is not reset; only the read register is.
module sfifo_mem #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with occupancy count and programmable thresholds.
// Define SFIFO_ERR_EN to add sticky overflow/underflow flags.
module sync_fifo_prog
  import fifo_pkg::*;
#(
  parameter int DATASIZE   = 8,
  parameter int ADDRSIZE   = 4,
  parameter int AFULL_THR  = 12,
  parameter int AEMPTY_THR = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                winc,
  input  logic [DATASIZE-1:0] wdata,
  output logic                wfull,
  output logic                walmost_full,
  input  logic                rinc,
  output logic [DATASIZE-1:0] rdata,
  output logic                rempty,
  output logic                ralmost_empty,
  output logic [ADDRSIZE:0]   count
`ifdef SFIFO_ERR_EN
  ,
  output logic                overflow,
  output logic                underflow
`endif
);

  localparam int DEPTH = depth_of(ADDRSIZE);
  localparam int PW    = ptr_width(ADDRSIZE);

  localparam logic [PW-1:0] FULL_C = PW'(DEPTH);
  localparam logic [PW-1:0] AF_C   = PW'(AFULL_THR);
  localparam logic [PW-1:0] AE_C   = PW'(AEMPTY_THR);

  if (!thr_ok(ADDRSIZE, AFULL_THR, AEMPTY_THR)) begin : g_bad_thr
    $error("sync_fifo_prog: illegal threshold parameters");
  end

  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          wr_ok;
  logic          rd_ok;

  assign wfull         = (count == FULL_C);
  assign rempty        = (count == '0);
  assign walmost_full  = (count >= AF_C);
  assign ralmost_empty = (count <= AE_C);

  assign wr_ok = winc & ~wfull;
  assign rd_ok = rinc & ~rempty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd_ok) rptr <= rptr + 1'b1;
      unique case (1'b1)
        wr_ok & ~rd_ok: count <= count + 1'b1;
        rd_ok & ~wr_ok: count <= count - 1'b1;
        default:        count <= count;
      endcase
    end
  end

`ifdef SFIFO_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= overflow  | (winc & wfull);
      underflow <= underflow | (rinc & rempty);
    end
  end
`endif

  sfifo_mem #(
    .DW(DATASIZE),
    .AW(ADDRSIZE)
  ) u_mem (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (wr_ok),
    .waddr(wptr[ADDRSIZE-1:0]),
    .wdata(wdata),
    .re   (rd_ok),
    .raddr(rptr[ADDRSIZE-1:0]),
    .rdata(rdata)
  );

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Bench for sync_fifo_prog: directed plan plus random traffic
// against a queue-based reference model.
module tb_sync_fifo_prog;

  localparam int DEPTH = 16;
  localparam int AF    = 12;
  localparam int AE    = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       winc;
  logic [7:0] wdata;
  logic       wfull;
  logic       walmost_full;
  logic       rinc;
  logic [7:0] rdata;
  logic       rempty;
  logic       ralmost_empty;
  logic [4:0] count;
`ifdef SFIFO_ERR_EN
  logic       overflow;
  logic       underflow;
`endif

  sync_fifo_prog dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .winc         (winc),
    .wdata        (wdata),
    .wfull        (wfull),
    .walmost_full (walmost_full),
    .rinc         (rinc),
    .rdata        (rdata),
    .rempty       (rempty),
    .ralmost_empty(ralmost_empty),
    .count        (count)
`ifdef SFIFO_ERR_EN
    ,
    .overflow     (overflow),
    .underflow    (underflow)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] q [$];
  logic [7:0] m_rdata;
  bit         m_ovf;
  bit         m_unf;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_rdata = '0;
    m_ovf   = 0;
    m_unf   = 0;
  endtask

  task automatic check_all(input string tag);
    int n;
    n = q.size();
    check({tag, ".count"}, 32'(count), 32'(n));
    check({tag, ".rempty"}, 32'(rempty), 32'(n == 0));
    check({tag, ".wfull"}, 32'(wfull), 32'(n == DEPTH));
    check({tag, ".afull"}, 32'(walmost_full), 32'(n >= AF));
    check({tag, ".aempty"}, 32'(ralmost_empty), 32'(n <= AE));
    check({tag, ".rdata"}, 32'(rdata), 32'(m_rdata));
`ifdef SFIFO_ERR_EN
    check({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
    check({tag, ".unf"}, 32'(underflow), 32'(m_unf));
`endif
  endtask

  // Drive one clock of traffic from a negedge, update model, check.
  task automatic step(
    input string      tag,
    input bit         w,
    input logic [7:0] d,
    input bit         r
  );
    bit full;
    bit empty;
    winc  = w;
    wdata = d;
    rinc  = r;
    full  = (q.size() == DEPTH);
    empty = (q.size() == 0);
    if (w && full) m_ovf = 1;
    if (r && empty) m_unf = 1;
    if (r && !empty) m_rdata = q.pop_front();
    if (w && !full) q.push_back(d);
    @(posedge clk);
    @(negedge clk);
    winc = 1'b0;
    rinc = 1'b0;
    check_all(tag);
  endtask

  initial begin
    logic [7:0] d;
    rst_n = 1'b0;
    winc  = 1'b0;
    rinc  = 1'b0;
    wdata = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_all("reset");

    for (int i = 1; i <= 16; i++) step("fill", 1, 8'(i), 0);
    step("wr_full", 1, 8'hFF, 0);

    for (int i = 0; i < 16; i++) step("drain", 0, 8'h00, 1);
    check("drain.last", 32'(rdata), 32'h10);
    step("rd_empty", 0, 8'h00, 1);

    for (int i = 0; i < 8; i++) step("to8", 1, 8'(8'h20 + i), 0);
    d = 8'h40;
    for (int i = 0; i < 40; i++) begin
      step("both", 1, d, 1);
      d++;
    end

    while (q.size() < DEPTH) step("tofull", 1, 8'($urandom), 0);
    step("full_both", 1, 8'hEE, 1);
    while (q.size() > 0) step("drain2", 0, 8'h00, 1);
    step("empty_both", 1, 8'hA5, 1);
    step("rd_a5", 0, 8'h00, 1);
    check("a5", 32'(rdata), 32'hA5);

    step("unf", 0, 8'h00, 1);
    for (int i = 0; i < 10; i++) step("to10", 1, 8'(8'h60 + i), 0);
    while (q.size() < DEPTH) step("tofull2", 1, 8'h77, 0);
    step("ovf", 1, 8'h78, 0);
    while (q.size() > 10) step("to10b", 0, 8'h00, 1);

    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("midrst");
    #2 rst_n = 1'b1;
    @(negedge clk);
    check_all("post_rst");

    for (int i = 0; i < 400; i++) begin
      step("rand", 1'($urandom_range(0, 1)),
           8'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
